// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit's APB data-bank front-end.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Access size is funct3[1:0]; funct3[2] selects zero-extension for loads.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } lsu_size_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [2:0] BANK_WORD = 3'b010;

  function automatic lsu_size_e size_of(input logic [2:0] funct3);
    return lsu_size_e'(funct3[1:0]);
  endfunction

endpackage

// File: rtl/lsu_apb_master_if.sv
// Request/response handshake from the MEM stage plus the word-wide data-bank port.
interface lsu_apb_master_if #(
  parameter int DMEM_ADDR = 9
) ();

  logic                 req_valid_i;
  logic                 req_ready_o;
  logic                 req_we_i;
  logic [2:0]           req_funct3_i;
  logic [31:0]          req_addr_i;
  logic [31:0]          req_wdata_i;

  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [31:0]          rsp_rdata_o;
  logic                 rsp_err_o;

  logic [DMEM_ADDR-1:0] paddr_o;
  logic                 penable_o;
  logic                 pwrite_o;
  logic [31:0]          pwdata_o;
  logic [2:0]           pfunct_code_o;
  logic [31:0]          prdata_i;

  modport master (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
    input  rsp_ready_i, prdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output paddr_o, penable_o, pwrite_o, pwdata_o, pfunct_code_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
    output rsp_ready_i, prdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  paddr_o, penable_o, pwrite_o, pwdata_o, pfunct_code_o
  );

endinterface

// File: rtl/lsu_apb_master_align.sv
// Byte-lane alignment: request legality check, load extract/extend, store merge.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DMEM_W = 11
) (
  input  logic        chk_we,
  input  logic [2:0]  chk_funct3,
  input  logic [31:0] chk_addr,
  output logic        chk_err,

  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [31:0] shifted;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    chk_err = 1'b0;
    case (chk_funct3)
      LB, LH, LW, LBU, LHU: chk_err = 1'b0;
      default:              chk_err = 1'b1;
    endcase
    if (chk_we && chk_funct3[2])                                chk_err = 1'b1;
    if (size_of(chk_funct3) == SZ_HALF && chk_addr[0])          chk_err = 1'b1;
    if (size_of(chk_funct3) == SZ_WORD && chk_addr[1:0] != 2'b00) chk_err = 1'b1;
    if (|chk_addr[31:DMEM_W])                                   chk_err = 1'b1;
  end

  always_comb begin
    shifted   = word;
    load_data = word;
    case (size_of(funct3))
      SZ_BYTE: begin
        shifted   = word >> {offset, 3'b000};
        load_data = funct3[2] ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        shifted   = word >> {offset[1], 4'b0000};
        load_data = funct3[2] ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: load_data = word;
    endcase
  end

  always_comb begin
    merge_data = word;
    case (size_of(funct3))
      SZ_BYTE: merge_data[{offset, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: merge_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_apb_master.sv
// LSU data-bank master: one outstanding load/store, sub-word stores done as read-modify-write.
module lsu_apb_master
  import lsu_pkg::*;
#(
  parameter int DMEM_W    = 11,
  parameter int DMEM_ADDR = 9
) (
  input  logic               clk_i,
  input  logic               rst_i,
  lsu_apb_master_if.master   bus
);

  lsu_state_e        state_q, state_d;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [DMEM_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              accept;
  logic              chk_err;
  logic [31:0]       align_word;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;

  assign accept     = (state_q == IDLE) && bus.req_valid_i;
  // Loads extract straight from the bank word so the result is ready at the RD edge.
  assign align_word = (state_q == RD) ? bus.prdata_i : word_q;

  lsu_align #(.DMEM_W(DMEM_W)) u_align (
    .chk_we     (bus.req_we_i),
    .chk_funct3 (bus.req_funct3_i),
    .chk_addr   (bus.req_addr_i),
    .chk_err    (chk_err),
    .funct3     (funct3_q),
    .offset     (addr_q[1:0]),
    .word       (align_word),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (chk_err)                                                state_d = RESP;
          else if (!bus.req_we_i || size_of(bus.req_funct3_i) != SZ_WORD) state_d = RD;
          else                                                        state_d = WR;
        end
      end
      RD:      state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        err_q   <= chk_err;
        rdata_q <= '0;
      end else if (state_q == RD && !we_q) begin
        rdata_q <= load_data;
      end
    end
  end

  // NOTE: pure datapath registers carry no reset; they are always written before being consumed.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q     <= bus.req_we_i;
      funct3_q <= bus.req_funct3_i;
      addr_q   <= bus.req_addr_i[DMEM_W-1:0];
      wdata_q  <= bus.req_wdata_i;
    end
    if (state_q == RD) word_q <= bus.prdata_i;
  end

  assign bus.req_ready_o   = (state_q == IDLE);
  assign bus.rsp_valid_o   = (state_q == RESP);
  assign bus.rsp_err_o     = (state_q == RESP) && err_q;
  assign bus.rsp_rdata_o   = (state_q == RESP) ? rdata_q : 32'h0;

  // Bank strobes are gated by reset so an interrupted RMW never lands.
  assign bus.penable_o     = ((state_q == RD) || (state_q == WR)) && !rst_i;
  assign bus.pwrite_o      = (state_q == WR) && !rst_i;
  assign bus.paddr_o       = addr_q[DMEM_W-1:2];
  assign bus.pwdata_o      = merge_data;
  assign bus.pfunct_code_o = BANK_WORD;

endmodule

// File: tb/tb_lsu_apb_master.sv
// Directed self-checking bench for lsu_apb_master with a behavioural word-wide bank.
module tb_lsu_apb_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_apb_master_if #(.DMEM_ADDR(9)) bus ();

  lsu_apb_master #(.DMEM_W(11), .DMEM_ADDR(9)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [31:0] mem [0:511];
  logic        pl_en = 1'b0;
  logic [8:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  assign bus.prdata_i = mem[bus.paddr_o];

  always @(posedge clk) begin
    if (bus.penable_o && bus.pwrite_o) mem[bus.paddr_o] <= bus.pwdata_o;
    else if (pl_en)                    mem[pl_addr]     <= pl_data;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Issues one request, returns once the response is visible (or the bound expires).
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic hold,
                     output logic [31:0] rd, output logic err, output int lat,
                     output int n_rd, output int n_wr,
                     output logic [31:0] wr_data, output logic [8:0] wr_addr);
    logic found;
    @(negedge clk);
    check("req_ready", {31'h0, bus.req_ready_o}, 32'd1);
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = we;
    bus.req_funct3_i = f3;
    bus.req_addr_i   = addr;
    bus.req_wdata_i  = wd;
    bus.rsp_ready_i  = !hold;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    found = 1'b0; lat = 0; n_rd = 0; n_wr = 0;
    rd = '0; err = 1'b0; wr_data = '0; wr_addr = '0;
    while (!found && lat < 8) begin
      @(negedge clk);
      lat++;
      if (bus.penable_o) begin
        if (bus.pwrite_o) begin
          n_wr++;
          wr_data = bus.pwdata_o;
          wr_addr = bus.paddr_o;
        end else begin
          n_rd++;
        end
      end
      if (bus.rsp_valid_o) begin
        found = 1'b1;
        rd    = bus.rsp_rdata_o;
        err   = bus.rsp_err_o;
      end
    end
    check("rsp_seen", {31'h0, found}, 32'd1);
  endtask

  logic [31:0] rd, wr_data;
  logic        err;
  logic [8:0]  wr_addr;
  int          lat, n_rd, n_wr;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
  } bad_req_t;

  bad_req_t bad [4];

  initial begin
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_funct3_i = 3'b000;
    bus.req_addr_i   = '0;
    bus.req_wdata_i  = '0;
    bus.rsp_ready_i  = 1'b1;

    pl_en = 1'b1; pl_addr = 9'd5; pl_data = 32'h8899AABB;
    repeat (2) @(posedge clk);
    pl_en = 1'b0;
    @(negedge clk);
    check("rst_ready",   {31'h0, bus.req_ready_o}, 32'd1);
    check("rst_valid",   {31'h0, bus.rsp_valid_o}, 32'd0);
    check("rst_err",     {31'h0, bus.rsp_err_o},   32'd0);
    check("rst_rdata",   bus.rsp_rdata_o,          32'd0);
    check("rst_penable", {31'h0, bus.penable_o},   32'd0);
    check("rst_pwrite",  {31'h0, bus.pwrite_o},    32'd0);
    check("funct_code",  {29'h0, bus.pfunct_code_o}, 32'd2);
    rst = 1'b0;

    // Byte loads from word 5 = 0x8899AABB.
    txn(1'b0, 3'b000, 32'h017, 32'h0, 1'b0, rd, err, lat, n_rd, n_wr, wr_data, wr_addr);
    check("lb_rdata", rd, 32'hFFFFFF88);
    check("lb_err",   {31'h0, err}, 32'd0);
    check("lb_lat",   lat, 32'd2);
    check("lb_nrd",   n_rd, 32'd1);
    txn(1'b0, 3'b100, 32'h017, 32'h0, 1'b0, rd, err, lat, n_rd, n_wr, wr_data, wr_addr);
    check("lbu_rdata", rd, 32'h00000088);
    txn(1'b0, 3'b000, 32'h016, 32'h0, 1'b0, rd, err, lat, n_rd, n_wr, wr_data, wr_addr);
    check("lb16_rdata", rd, 32'hFFFFFF99);

    // Sub-word store read-modify-write.
    txn(1'b1, 3'b000, 32'h015, 32'h123456CC, 1'b0, rd, err, lat, n_rd, n_wr, wr_data, wr_addr);
    check("sb_lat",    lat, 32'd3);
    check("sb_nrd",    n_rd, 32'd1);
    check("sb_nwr",    n_wr, 32'd1);
    check("sb_pwdata", wr_data, 32'h8899CCBB);
    check("sb_rdata",  rd, 32'h0);
    check("sb_err",    {31'h0, err}, 32'd0);
    txn(1'b0, 3'b010, 32'h014, 32'h0, 1'b0, rd, err, lat, n_rd, n_wr, wr_data, wr_addr);
    check("lw_after_sb", rd, 32'h8899CCBB);

    // Word store skips the read.
    txn(1'b1, 3'b010, 32'h020, 32'hDEADBEEF, 1'b0, rd, err, lat, n_rd, n_wr, wr_data, wr_addr);
    check("sw_lat",    lat, 32'd2);
    check("sw_nrd",    n_rd, 32'd0);
    check("sw_nwr",    n_wr, 32'd1);
    check("sw_paddr",  {23'h0, wr_addr}, 32'd8);
    check("sw_pwdata", wr_data, 32'hDEADBEEF);
    txn(1'b0, 3'b101, 32'h022, 32'h0, 1'b0, rd, err, lat, n_rd, n_wr, wr_data, wr_addr);
    check("lhu_rdata", rd, 32'h0000DEAD);
    txn(1'b0, 3'b001, 32'h020, 32'h0, 1'b0, rd, err, lat, n_rd, n_wr, wr_data, wr_addr);
    check("lh_rdata", rd, 32'hFFFFBEEF);

    // Half store into upper lanes.
    txn(1'b1, 3'b001, 32'h022, 32'h00001234, 1'b0, rd, err, lat, n_rd, n_wr, wr_data, wr_addr);
    check("sh_pwdata", wr_data, 32'h1234BEEF);

    // Rejected requests never touch the bank.
    bad[0] = '{we: 1'b0, f3: 3'b010, addr: 32'h013};
    bad[1] = '{we: 1'b1, f3: 3'b001, addr: 32'h021};
    bad[2] = '{we: 1'b0, f3: 3'b000, addr: 32'h800};
    bad[3] = '{we: 1'b0, f3: 3'b011, addr: 32'h000};
    for (int i = 0; i < 4; i++) begin
      txn(bad[i].we, bad[i].f3, bad[i].addr, 32'hFFFFFFFF, 1'b0, rd, err, lat, n_rd, n_wr, wr_data, wr_addr);
      check($sformatf("bad%0d_err", i),   {31'h0, err}, 32'd1);
      check($sformatf("bad%0d_rdata", i), rd, 32'h0);
      check($sformatf("bad%0d_lat", i),   lat, 32'd1);
      check($sformatf("bad%0d_bank", i),  n_rd + n_wr, 32'd0);
    end
    txn(1'b1, 3'b100, 32'h014, 32'h0, 1'b0, rd, err, lat, n_rd, n_wr, wr_data, wr_addr);
    check("store_unsigned_err", {31'h0, err}, 32'd1);

    // Response back-pressure.
    txn(1'b0, 3'b010, 32'h014, 32'h0, 1'b1, rd, err, lat, n_rd, n_wr, wr_data, wr_addr);
    check("hold_first", rd, 32'h8899CCBB);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_valid", {31'h0, bus.rsp_valid_o}, 32'd1);
      check("hold_rdata", bus.rsp_rdata_o, 32'h8899CCBB);
      check("hold_ready", {31'h0, bus.req_ready_o}, 32'd0);
    end
    bus.rsp_ready_i = 1'b1;
    txn(1'b0, 3'b100, 32'h014, 32'h0, 1'b0, rd, err, lat, n_rd, n_wr, wr_data, wr_addr);
    check("after_hold", rd, 32'h000000BB);

    // Reset during the write phase of a byte store.
    @(negedge clk);
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = 1'b1;
    bus.req_funct3_i = 3'b000;
    bus.req_addr_i   = 32'h014;
    bus.req_wdata_i  = 32'h00000077;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    @(negedge clk);
    check("rst_rd_phase", {30'h0, bus.penable_o, bus.pwrite_o}, 32'd2);
    @(negedge clk);
    check("rst_wr_phase", {30'h0, bus.penable_o, bus.pwrite_o}, 32'd3);
    rst = 1'b1;
    #1 check("rst_gate_penable", {31'h0, bus.penable_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mem_kept",   mem[5], 32'h8899CCBB);
    check("rst_ready_back", {31'h0, bus.req_ready_o}, 32'd1);
    check("rst_no_rsp",     {31'h0, bus.rsp_valid_o}, 32'd0);
    txn(1'b0, 3'b010, 32'h014, 32'h0, 1'b0, rd, err, lat, n_rd, n_wr, wr_data, wr_addr);
    check("rst_lw", rd, 32'h8899CCBB);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
